// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU. It takes 33 cycles from the
// start edge to done and returns the quotient (LO) and the remainder (HI).
module div_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [31:0]        quo;
  logic [31:0]        rem;
  logic [31:0]        dsr_mag;
  logic [31:0]        dvd_orig;
  logic               q_neg;
  logic               r_neg;
  logic               dz;
  logic signed [32:0] trial;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // rem < divisor holds throughout, so the difference always fits in 33 signed bits.
  assign trial = {rem, quo[31]} - {1'b0, dsr_mag};

  // Datapath: magnitude capture, then one quotient bit per ITER cycle.
  // quo starts out holding the dividend magnitude and fills with quotient bits.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        quo      <= (is_signed && dividend[31]) ? neg32(dividend) : dividend;
        dsr_mag  <= (is_signed && divisor[31]) ? neg32(divisor) : divisor;
        dvd_orig <= dividend;
        q_neg    <= is_signed & (dividend[31] ^ divisor[31]);
        r_neg    <= is_signed & dividend[31];
        dz       <= (divisor == 32'd0);
        rem      <= 32'd0;
      end
      ITER: begin
        if (!trial[32]) begin
          rem <= trial[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= {rem[30:0], quo[31]};
          quo <= {quo[30:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= 32'd0;
      r        <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ITER;
          cnt   <= 5'd0;
          busy  <= 1'b1;
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz;
          if (dz) begin
            q <= 32'hFFFF_FFFF;
            r <= dvd_orig;
          end else begin
            q <= q_neg ? neg32(quo) : quo;
            r <= r_neg ? neg32(rem) : rem;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a cycle-level reference model checked on every falling edge,
// together with directed divisions whose results are written out by hand.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  int n_cmp = 0;
  int n_fail = 0;

  div_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .q(q), .r(r), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: plain division on the operands.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eq, output logic [31:0] er,
                                  output logic edz);
    longint sa, sb, qq, rr;
    edz = 1'b0;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
      edz = 1'b1;
    end else if (!s) begin
      eq = a / b;
      er = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      qq = sa / sb;
      rr = sa % sb;
      eq = qq[31:0];
      er = rr[31:0];
    end
  endfunction

  // Model: one operation in flight, and the result appears 33 edges after acceptance.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_q = 32'd0;
  logic [31:0] m_r = 32'd0;
  logic        m_dz = 1'b0;
  logic [31:0] p_q, p_r;
  logic        p_dz;
  int          cd = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 1'b0; m_done = 1'b0; m_q = 32'd0; m_r = 32'd0; m_dz = 1'b0; cd = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        cd--;
        if (cd == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (start) begin
        ref_div(is_signed, dividend, divisor, p_q, p_r, p_dz);
        cd = 33;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk)
    chk("cycle{busy,done,q,r,dz}", {busy, done, q, r, div_zero},
        {m_busy, m_done, m_q, m_r, m_dz});

  // Drive operands for one edge, then scramble them to show they are not re-read.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input string nm, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz);
    int cyc = 0;
    int bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc, 33);
    chk({nm, " busy cycles"}, bcnt, 33);
    chk({nm, " q/r/dz"}, {q, r, div_zero}, {eq, er, edz});
  endtask

  task automatic do_div(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz);
    @(posedge clk); #1;
    launch(s, a, b);
    wait_done(nm, eq, er, edz);
  endtask

  initial begin
    int dcnt;
    logic [31:0] cq, cr;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("reset state", {busy, done, q, r, div_zero}, 96'd0);

    do_div("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    do_div("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div("u -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    do_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_div("s div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    do_div("u div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    do_div("u 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Back-to-back: start raised in the done cycle itself.
    launch(1'b0, 32'h0000_FFFF, 32'h10);
    wait_done("b2b ffff/10", 32'h0000_0FFF, 32'hF, 1'b0);

    // start held with new operands while busy must be ignored.
    @(posedge clk); #1;
    launch(1'b0, 32'd50, 32'd5);
    dcnt = 0; cq = 32'd0; cr = 32'd0;
    for (int c = 1; c <= 45; c++) begin
      if (c >= 5 && c <= 19) begin
        start = 1'b1; dividend = 32'd1; divisor = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin dcnt++; cq = q; cr = r; end
    end
    start = 1'b0;
    chk("ignore start done count", dcnt, 1);
    chk("ignore start q/r", {cq, cr}, {32'd10, 32'd0});

    // Reset in mid-division clears outputs at once and suppresses done.
    @(posedge clk); #1;
    launch(1'b0, 32'd50, 32'd5);
    repeat (11) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1 chk("async reset outputs", {busy, done, q, r, div_zero}, 96'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rstn = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no done after reset", dcnt, 0);

    do_div("s 9/-3 after reset", 1'b1, 32'd9, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0, 1'b0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
